id_ex_fwd_stage: RTL
====================

Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the baseline 5-stage core.
- Also generates the 2-bit forwarding selects consumed directly downstream by the two 4:1 EX operand muxes (A and B), and detects load-use hazards.
- Inserts bubbles on load-use hazards and branch flushes, and freezes on global memory stall.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width (x0 hard-wired zero)

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  global memory stall (cache miss); freezes stage
flush_i  in  1  branch taken; squash instruction entering EX
id_valid_i  in  1  ID holds a real instruction
id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  ID register addresses
id_use_rs1_i, id_use_rs2_i  in  1  instruction actually reads rs1/rs2
id_regwrite_i, id_memread_i, id_alusrc_i  in  1  ID controls
id_rs1_data_i, id_rs2_data_i, id_imm_i  in  DATA_W  register file reads, immediate
mem_rd_i  in  REG_AW  MEM-stage destination
mem_regwrite_i  in  1  MEM-stage write enable
wb_rd_i  in  REG_AW  WB-stage destination
wb_regwrite_i  in  1  WB-stage write enable
wb_data_i  in  DATA_W  WB write data
ex_valid_o, ex_regwrite_o, ex_memread_o, ex_alusrc_o  out  1  registered controls
ex_rd_o  out  REG_AW  registered destination
ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  DATA_W  registered operands
fwdA_sel_o, fwdB_sel_o  out  2  registered mux selects
hazard_stall_o  out  1  combinational; hold PC and IF/ID

Behaviour:
- Reset (rst_n=0, async): all registered outputs 0, including selects (00).
- Update priority at each clk_i edge: stall_i > flush_i > load-use bubble > normal load.
- stall_i=1: every register holds its value; selects stay valid because the whole pipeline is frozen.
- flush_i=1 or load-use bubble: ex_valid/regwrite/memread/alusrc = 0, ex_rd = 0, fwd selects = 00. Data registers may load, but are don't-care.
- Load-use condition (combinational):
  - Terms: id_valid_i & ex_valid_o & ex_memread_o & ex_rd_o≠0.
  - Match term: (id_use_rs1_i & id_rs1_i==ex_rd_o) | (id_use_rs2_i & id_rs2_i==ex_rd_o).
  - hazard_stall_o = condition & ~flush_i & ~stall_i.
- Normal load: all ID fields are registered with ex_valid_o = id_valid_i.
- fwdA_sel computed for rs1 (first match wins):
  - 10 (MEM ALU result next cycle): ex_valid_o & ex_regwrite_o & ex_rd_o≠0 & ex_rd_o==rs1.
  - 01 (WB data next cycle): mem_regwrite_i & mem_rd_i≠0 & mem_rd_i==rs1.
  - 00 otherwise (register file value).
  - Never 11.
- fwdB_sel: same rules for rs2, except id_alusrc_i=1 forces 11 (immediate). The rs2 data path is still registered for store data.
- WB capture: if wb_regwrite_i & wb_rd_i≠0 & wb_rd_i==rsN at load time, ex_rsN_data_o captures wb_data_i instead of the register file read. This covers the same-cycle register file write.
- rsN with id_use_rsN_i=0 forces its select to 00 (and 11 rules still apply for B).
- x0 never forwarded or captured. Latency is 1 cycle ID→EX; a load-use hazard costs exactly 1 bubble.
- flush_i during a load-use condition: flush wins and hazard_stall_o=0.
- Async reset mid-stall clears everything; the first post-reset edge performs a normal load.

Optional Feature:
- Macro: HAZARD_CNT_EN.
- Defined: adds output load_use_cnt_o [15:0], which increments on each edge that inserts a load-use bubble. It saturates at 16'hFFFF, resets to 0, and holds under stall_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Stimulus: reset asserted mid-operation with nonzero outputs. Required response: all outputs 0 immediately (async), selects 00, hazard_stall_o=0.
- Stimulus: ADD x5 then SUB x6,x5,x7 back-to-back. Required response: SUB enters EX with fwdA_sel=10, fwdB_sel=00; one instruction later, a reader of x5 gets sel=01.
- Stimulus: LW x3 then ADD x4,x3,x3.
  - Required response: hazard_stall_o=1 for one cycle, and the next EX slot is a bubble (ex_valid=0, ex_regwrite=0).
  - ADD then enters with fwdA=fwdB=01.
  - With HAZARD_CNT_EN defined, load_use_cnt_o=1.
- Stimulus: producer writing x0 followed by a reader of x0. Required response: selects 00; WB capture not taken.
- Stimulus: WB writes x9=32'hDEADBEEF in the same cycle ID reads stale x9 with id_alusrc_i=1. Required response: ex_rs1_data_o=32'hDEADBEEF, fwdB_sel=11.
- Stimulus: stall_i high for 3 cycles during a load-use condition, then flush_i with a valid ID. Required response: outputs frozen and hazard_stall_o=0 while stalled; after the flush edge ex_valid_o=0.

Source files
------------

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with operand-forward select generation and
// load-use hazard detection.
// Optional feature macro: HAZARD_CNT_EN adds a saturating load-use bubble
// counter (load_use_cnt_o). The default build omits it.
module id_ex_fwd_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_alusrc_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              ex_valid_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_alusrc_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [1:0]        fwdA_sel_o,
    output logic [1:0]        fwdB_sel_o,
    output logic              hazard_stall_o
`ifdef HAZARD_CNT_EN
    ,
    output logic [15:0]       load_use_cnt_o
`endif
);

    logic              ex_valid_q, ex_valid_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic              ex_alusrc_q, ex_alusrc_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [DATA_W-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic              load_use;

    // Select for one source operand: EX producer (result in MEM next cycle)
    // beats MEM producer (value in WB next cycle); x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic              use_rs,
                                           input logic              ex_v,
                                           input logic              ex_rw,
                                           input logic [REG_AW-1:0] ex_rd,
                                           input logic              mem_rw,
                                           input logic [REG_AW-1:0] mem_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_rs) begin
            if (ex_v && ex_rw && (ex_rd != '0) && (ex_rd == rs))
                sel = 2'b10;
            else if (mem_rw && (mem_rd != '0) && (mem_rd == rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    // Load-use: instruction in ID reads the destination of a load now in EX.
    always_comb begin
        load_use = id_valid_i && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
                   ((id_use_rs1_i && (id_rs1_i == ex_rd_q)) ||
                    (id_use_rs2_i && (id_rs2_i == ex_rd_q)));
        hazard_stall_o = load_use && !flush_i && !stall_i;
    end

    // Next-state: stall holds, flush/bubble clears controls, else normal load.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        ex_alusrc_d   = ex_alusrc_q;
        ex_rd_d       = ex_rd_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        fwd_a_d       = fwd_a_q;
        fwd_b_d       = fwd_b_q;
        if (!stall_i) begin
            // Data always loads; it is ignored behind a bubble. A same-cycle
            // WB write bypasses the stale register file read.
            ex_rs1_data_d = (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_rs1_i))
                            ? wb_data_i : id_rs1_data_i;
            ex_rs2_data_d = (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_rs2_i))
                            ? wb_data_i : id_rs2_data_i;
            ex_imm_d      = id_imm_i;
            if (flush_i || load_use) begin
                ex_valid_d    = 1'b0;
                ex_regwrite_d = 1'b0;
                ex_memread_d  = 1'b0;
                ex_alusrc_d   = 1'b0;
                ex_rd_d       = '0;
                fwd_a_d       = 2'b00;
                fwd_b_d       = 2'b00;
            end else begin
                ex_valid_d    = id_valid_i;
                ex_regwrite_d = id_regwrite_i;
                ex_memread_d  = id_memread_i;
                ex_alusrc_d   = id_alusrc_i;
                ex_rd_d       = id_rd_i;
                fwd_a_d       = fwd_sel(id_rs1_i, id_use_rs1_i, ex_valid_q, ex_regwrite_q,
                                        ex_rd_q, mem_regwrite_i, mem_rd_i);
                fwd_b_d       = id_alusrc_i ? 2'b11
                              : fwd_sel(id_rs2_i, id_use_rs2_i, ex_valid_q, ex_regwrite_q,
                                        ex_rd_q, mem_regwrite_i, mem_rd_i);
            end
        end
    end

    // Pipeline register bank.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_alusrc_q   <= 1'b0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            fwd_a_q       <= 2'b00;
            fwd_b_q       <= 2'b00;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
        end
    end

`ifdef HAZARD_CNT_EN
    logic [15:0] load_use_cnt_q, load_use_cnt_d;

    // Count bubbles inserted for load-use, saturating at all ones.
    always_comb begin
        load_use_cnt_d = load_use_cnt_q;
        if (hazard_stall_o && (load_use_cnt_q != 16'hFFFF))
            load_use_cnt_d = load_use_cnt_q + 16'd1;
    end

    // Bubble counter register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) load_use_cnt_q <= '0;
        else        load_use_cnt_q <= load_use_cnt_d;
    end

    assign load_use_cnt_o = load_use_cnt_q;
`endif

    assign ex_valid_o    = ex_valid_q;
    assign ex_regwrite_o = ex_regwrite_q;
    assign ex_memread_o  = ex_memread_q;
    assign ex_alusrc_o   = ex_alusrc_q;
    assign ex_rd_o       = ex_rd_q;
    assign ex_rs1_data_o = ex_rs1_data_q;
    assign ex_rs2_data_o = ex_rs2_data_q;
    assign ex_imm_o      = ex_imm_q;
    assign fwdA_sel_o    = fwd_a_q;
    assign fwdB_sel_o    = fwd_b_q;

endmodule
